// File: rtl/npc_pkg.sv
// Shared NPC core definitions: widths, RV32 load/store
// funct3 encodings and the LSU state encoding.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT,
        LSU_DONE,
        LSU_BYPASS
    } lsu_state_e;

    // Low two funct3 bits give the access size; anything
    // that is not a byte or half is handled as a word.
    function automatic logic is_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic r;
        case (f3[1:0])
            2'b00:   r = 1'b0;
            2'b01:   r = off[0];
            default: r = |off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: store mask/data
// replication and load extract/extend.
module lsu_align
    import npc_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wmask,
    output logic [XLEN-1:0] wdata_sh,
    output logic [XLEN-1:0] rdata_ext
);

    logic [XLEN-1:0] rd_b;
    logic [XLEN-1:0] rd_h;

    assign rd_b = rdata >> {off, 3'b000};
    assign rd_h = rdata >> {off[1], 4'b0000};

    // Size from funct3[1:0], zero-extension from funct3[2]
    always_comb begin
        wmask     = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rdata;
        case (funct3[1:0])
            2'b00: begin
                wmask     = 4'b0001 << off;
                wdata_sh  = {4{wdata[7:0]}};
                rdata_ext = funct3[2] ? {24'b0, rd_b[7:0]}
                                      : {{24{rd_b[7]}}, rd_b[7:0]};
            end
            2'b01: begin
                wmask     = 4'b0011 << off;
                wdata_sh  = {2{wdata[15:0]}};
                rdata_ext = funct3[2] ? {16'b0, rd_h[15:0]}
                                      : {{16{rd_h[15]}}, rd_h[15:0]};
            end
            default: begin
                wmask     = 4'b1111;
                wdata_sh  = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// NPC load/store stage: one op at a time from EXU to
// pmem and back to WBU, with misalign and timeout errors.
module lsu_mem_stage
    import npc_pkg::*;
#(
    parameter int TIMEOUT_CYC    = 255,
    parameter int RESET_PC_ALIGN = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic [4:0]  out_rd,
    output logic        out_err
);

    localparam int AL = RESET_PC_ALIGN;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    lsu_state_e state, state_n;

    logic            wen_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt;

    logic [3:0]      wmask;
    logic [XLEN-1:0] wdata_sh;
    logic [XLEN-1:0] rdata_ext;
    logic            timeout_hit;
    logic            is_req;

    lsu_align u_align (
        .funct3    (f3_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    assign timeout_hit = (TIMEOUT_CYC != 0) &&
                         (cnt == CW'(TIMEOUT_CYC - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LSU_IDLE;
        else        state <= state_n;
    end

    // Next-state: a response beats a same-cycle timeout
    always_comb begin
        state_n = state;
        unique case (state)
            LSU_IDLE: begin
                if (in_valid) begin
                    if (!in_ren && !in_wen)
                        state_n = LSU_BYPASS;
                    else if (is_misaligned(in_funct3, in_addr[1:0]))
                        state_n = LSU_DONE;
                    else
                        state_n = LSU_REQ;
                end
            end
            LSU_REQ:  if (mem_ready) state_n = LSU_WAIT;
            LSU_WAIT: if (mem_rsp_valid || timeout_hit)
                          state_n = LSU_DONE;
            LSU_DONE, LSU_BYPASS:
                      if (out_ready) state_n = LSU_IDLE;
            default:  state_n = LSU_IDLE;
        endcase
    end

    // WAIT cycle counter, cleared whenever not waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (state == LSU_WAIT) cnt <= cnt + 1'b1;
        else                        cnt <= '0;
    end

    // Op capture in IDLE and result capture in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state == LSU_IDLE && in_valid) begin
            wen_q   <= in_wen;
            f3_q    <= in_funct3;
            addr_q  <= in_addr;
            wdata_q <= in_wdata;
            rd_q    <= in_rd;
            rdata_q <= '0;
            err_q   <= (in_ren || in_wen) &&
                       is_misaligned(in_funct3, in_addr[1:0]);
        end else if (state == LSU_WAIT) begin
            if (mem_rsp_valid) begin
                rdata_q <= wen_q ? '0 : rdata_ext;
                err_q   <= 1'b0;
            end else if (timeout_hit) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
        end
    end

    assign is_req    = (state == LSU_REQ);
    assign in_ready  = (state == LSU_IDLE);
    assign mem_valid = is_req;
    assign mem_wen   = is_req && wen_q;
    assign mem_addr  = is_req ? {addr_q[XLEN-1:AL], {AL{1'b0}}} : '0;
    assign mem_wmask = (is_req && wen_q) ? {4'b0, wmask} : 8'h00;
    assign mem_wdata = (is_req && wen_q) ? wdata_sh : '0;

    assign out_valid = (state == LSU_DONE) || (state == LSU_BYPASS);
    assign out_rdata = out_valid ? rdata_q : '0;
    assign out_rd    = out_valid ? rd_q : '0;
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: randomized ops,
// behavioural reference model, decoupled monitors.
module tb_lsu_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_ren = 1'b0;
    logic        in_wen = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic [4:0]  out_rd;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    logic busy = 1'b0;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [7:0]  mask;
        logic [31:0] data;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];
    int   lat_q[$];

    lsu_mem_stage #(.TIMEOUT_CYC(TO), .RESET_PC_ALIGN(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ren        (in_ren),
        .in_wen        (in_wen),
        .in_funct3     (in_funct3),
        .in_addr       (in_addr),
        .in_wdata      (in_wdata),
        .in_rd         (in_rd),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_rdata     (out_rdata),
        .out_rd        (out_rd),
        .out_err       (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3,
            input logic [31:0] addr, input logic [31:0] rdata);
        int sz = size_of(f3);
        int off = int'(addr % 4);
        longint unsigned v;
        longint unsigned lim;
        v   = longint'(rdata) >> (8 * off);
        lim = longint'(1) << (8 * sz);
        v   = v % lim;
        if ((f3 == 3'b000 || f3 == 3'b001) && v >= lim / 2)
            v = v + (longint'(1) << 32) - lim;
        return v[31:0];
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (mem_valid) begin
            if (req_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_mem_valid: got 1 expected 0 at %0t",
                         $time);
            end else begin
                chk("mem_wen", {31'b0, mem_wen}, {31'b0, req_q[0].wen});
                chk("mem_addr", mem_addr, req_q[0].addr);
                chk("mem_wmask", {24'b0, mem_wmask}, {24'b0, req_q[0].mask});
                if (req_q[0].wen)
                    chk("mem_wdata", mem_wdata, req_q[0].data);
                if (mem_ready) void'(req_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (out_valid) begin
            if (res_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t",
                         $time);
            end else begin
                chk("out_rdata", out_rdata, res_q[0].rdata);
                chk("out_rd", {27'b0, out_rd}, {27'b0, res_q[0].rd});
                chk("out_err", {31'b0, out_err}, {31'b0, res_q[0].err});
                if (out_ready) void'(res_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", {31'b0, in_ready}, {31'b0, ~busy});
    end

    int  lat_cnt = 0;
    bit  counting = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            counting = 1'b0;
        end else begin
            if (counting) lat_cnt++;
            if (counting && out_valid) begin
                counting = 1'b0;
                if (lat_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL latency_queue: got empty expected entry");
                end else begin
                    chk("wait_latency", lat_cnt, lat_q.pop_front());
                end
            end
            if (mem_valid && mem_ready) begin
                counting = 1'b1;
                lat_cnt  = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_op(input logic ren, input logic wen,
            input logic [2:0] f3, input logic [31:0] addr,
            input logic [31:0] wdata, input logic [31:0] rdata,
            input logic [4:0] rd, input int rdly, input int sdly,
            input int odly);
        int   sz = size_of(f3);
        bit   mis = (addr % sz) != 0;
        bit   go  = (ren || wen) && !mis;
        bit   tmo = (sdly < 0) || (sdly >= TO);
        req_t q;
        res_t r;
        int   n;
        r.rd = rd;
        r.err = 1'b0;
        r.rdata = '0;
        if ((ren || wen) && mis) begin
            r.err = 1'b1;
        end else if (go) begin
            q.wen  = wen;
            q.addr = addr - (addr % 4);
            q.mask = '0;
            q.data = '0;
            if (wen) begin
                q.mask = 8'(((1 << sz) - 1) << (addr % 4));
                q.data = (sz == 1) ? {24'b0, wdata[7:0]} * 32'h01010101 :
                         (sz == 2) ? {16'b0, wdata[15:0]} * 32'h00010001 :
                                     wdata;
            end
            req_q.push_back(q);
            lat_q.push_back(tmo ? TO + 1 : sdly + 2);
            if (tmo)       r.err = 1'b1;
            else if (!wen) r.rdata = load_val(f3, addr, rdata);
        end
        res_q.push_back(r);

        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL in_ready_wait: got 0 expected 1");
        end
        in_valid = 1'b1; in_ren = ren; in_wen = wen;
        in_funct3 = f3; in_addr = addr; in_wdata = wdata; in_rd = rd;
        tick();
        in_valid = 1'b0; busy = 1'b1;
        in_addr = $urandom; in_wdata = $urandom;
        in_rd = 5'($urandom); in_funct3 = 3'($urandom);
        if (go) begin
            repeat (rdly) tick();
            mem_ready = 1'b1;
            n = 0;
            while (!mem_valid && n < 50) begin tick(); n++; end
            tick();
            mem_ready = 1'b0;
            if (sdly >= 0) begin
                repeat (sdly) tick();
                mem_rsp_valid = 1'b1; mem_rdata = rdata;
                tick();
                mem_rsp_valid = 1'b0; mem_rdata = $urandom;
            end
        end
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL out_valid_wait: got 0 expected 1");
        end
        repeat (odly) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; busy = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_mem_valid"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, "_out_rdata"}, out_rdata, 32'd0);
        chk({tag, "_out_err"}, {31'b0, out_err}, 32'd0);
        chk({tag, "_out_rd"}, {27'b0, out_rd}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wmask"}, {24'b0, mem_wmask}, 32'd0);
    endtask

    task automatic reset_in_wait();
        req_t q;
        q.wen = 1'b0; q.addr = 32'h80000010; q.mask = '0; q.data = '0;
        req_q.push_back(q);
        in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0;
        in_funct3 = 3'b010; in_addr = 32'h80000010; in_rd = 5'd9;
        tick();
        in_valid = 1'b0; busy = 1'b1; mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        rst_n = 1'b0; busy = 1'b0;
        tick();
        check_idle("in_reset");
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            tick();
            check_idle("after_stale_rsp");
        end
    endtask

    initial begin
        bit ren, wen;
        logic [2:0] f3;
        logic [31:0] a;
        int sd;
        repeat (2) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        run_op(1, 0, 3'b000, 32'h80000003, 0, 32'h80FF1234, 5'd1, 0, 0, 0);
        run_op(1, 0, 3'b100, 32'h80000003, 0, 32'h80FF1234, 5'd2, 0, 0, 0);
        run_op(0, 1, 3'b001, 32'h80000002, 32'h0000BEEF, 0, 5'd3, 0, 0, 0);
        run_op(1, 0, 3'b010, 32'h80000002, 0, 0, 5'd4, 0, 0, 0);
        run_op(1, 0, 3'b010, 32'h80000008, 0, 32'h12345678, 5'd5, 5, 1, 3);
        run_op(1, 0, 3'b010, 32'h8000000C, 0, 32'h11112222, 5'd6, 0, -1, 0);
        run_op(1, 0, 3'b001, 32'h8000000E, 0, 32'h9ABC0000, 5'd7, 0, 3, 0);
        run_op(0, 1, 3'b000, 32'h80000005, 32'h000000A5, 0, 5'd8, 0, 4, 1);
        run_op(0, 0, 3'b010, 32'h80000001, 0, 0, 5'd10, 0, 0, 2);
        run_op(1, 1, 3'b010, 32'h80000020, 32'hCAFEF00D, 0, 5'd11, 1, 0, 0);
        reset_in_wait();

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0:       begin ren = 0; wen = 0; end
                1:       begin ren = 1; wen = 1; end
                2, 3, 4: begin ren = 0; wen = 1; end
                default: begin ren = 1; wen = 0; end
            endcase
            if (wen)
                f3 = 3'($urandom_range(0, 2));
            else if ($urandom_range(0, 7) == 0)
                f3 = 3'($urandom);
            else
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
                    3: f3 = 3'b100; default: f3 = 3'b101;
                endcase
            a = 32'h80000000 | ($urandom & 32'h0000FFFF);
            case ($urandom_range(0, 7))
                0:       sd = -1;
                1:       sd = 4;
                default: sd = $urandom_range(0, 3);
            endcase
            run_op(ren, wen, f3, a, $urandom, $urandom, 5'($urandom),
                   $urandom_range(0, 3), sd, $urandom_range(0, 3));
        end

        repeat (3) tick();
        chk("req_q_drained", req_q.size(), 0);
        chk("res_q_drained", res_q.size(), 0);
        chk("lat_q_drained", lat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
